controlador_estacionamiento: RTL and testbench

Synchronous Moore controller for a single-lane parking-lot entry gate. It waits for a vehicle, validates an 8-bit PIN, opens the gate, and closes it once the vehicle has passed. Repeated wrong PINs raise an alarm, and a vehicle entering while the gate is still open (tailgating) locks the gate. It sits between the gate sensors and keypad on one side and the gate actuator and alarm on the other.

---
 rtl/controlador_estacionamiento_pkg.sv | 17 +
 rtl/controlador_estacionamiento.sv | 98 +++++++++
 tb/tb_controlador_estacionamiento.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/controlador_estacionamiento_pkg.sv
// Shared types and defaults for the parking-lot entry gate controller.
package controlador_estacionamiento_pkg;

    typedef enum logic [1:0] {
        ESPERA_VEHICULO = 2'd0,
        ESPERA_PIN      = 2'd1,
        ABIERTO         = 2'd2,
        BLOQUEO         = 2'd3
    } estado_e;

    localparam logic [7:0]  PIN_CORRECTO_DEF = 8'b0010_0100;
    localparam int unsigned MAX_INTENTOS_DEF = 3;

    localparam int unsigned         CNT_W   = 2;
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

endpackage

// File: rtl/controlador_estacionamiento.sv
// Moore entry-gate controller: vehicle detect, PIN check, open/close,
// wrong-PIN alarm and tailgating lock. All outputs are registered.
module controlador_estacionamiento
    import controlador_estacionamiento_pkg::*;
#(
    parameter logic [7:0]  PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter int unsigned MAX_INTENTOS = MAX_INTENTOS_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Pin,
    input  logic       Vehiculo,
    input  logic       Termino,
    output logic       Cerrado,
    output logic       Abierto,
    output logic       Alarma,
    output logic       Bloqueo
);

    estado_e          estado_q, estado_d;
    logic [CNT_W-1:0] intentos_q, intentos_d;
    logic             alarma_flag_q, alarma_flag_d;
    logic             cerrado_q, cerrado_d;
    logic             abierto_q, abierto_d;
    logic             alarma_q, alarma_d;
    logic             bloqueo_q, bloqueo_d;
    logic             pin_ok_c;
    logic             pin_vacio_c;

    assign pin_ok_c    = (Pin == PIN_CORRECTO);
    assign pin_vacio_c = (Pin == 8'h00);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            estado_q      <= ESPERA_VEHICULO;
            intentos_q    <= '0;
            alarma_flag_q <= 1'b0;
            cerrado_q     <= 1'b1;
            abierto_q     <= 1'b0;
            alarma_q      <= 1'b0;
            bloqueo_q     <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            intentos_q    <= intentos_d;
            alarma_flag_q <= alarma_flag_d;
            cerrado_q     <= cerrado_d;
            abierto_q     <= abierto_d;
            alarma_q      <= alarma_d;
            bloqueo_q     <= bloqueo_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        intentos_d    = intentos_q;
        alarma_flag_d = alarma_flag_q;

        case (estado_q)
            ESPERA_VEHICULO: begin
                if (Vehiculo) estado_d = ESPERA_PIN;
            end
            ESPERA_PIN: begin
                if (pin_ok_c) begin
                    estado_d      = ABIERTO;
                    intentos_d    = '0;
                    alarma_flag_d = 1'b0;
                end else if (!pin_vacio_c) begin
                    // Saturating count: each cycle a wrong code is present is one attempt
                    if (intentos_q != CNT_MAX) intentos_d = intentos_q + CNT_W'(1);
                    if (32'(intentos_d) >= MAX_INTENTOS) alarma_flag_d = 1'b1;
                end
            end
            ABIERTO: begin
                if (Termino) estado_d = Vehiculo ? BLOQUEO : ESPERA_VEHICULO;
            end
            BLOQUEO: begin
                if (pin_ok_c) begin
                    estado_d      = ESPERA_VEHICULO;
                    intentos_d    = '0;
                    alarma_flag_d = 1'b0;
                end
            end
            default: estado_d = ESPERA_VEHICULO;
        endcase

        // Outputs decoded from the next state so they land on the same edge as the state
        cerrado_d = (estado_d != ABIERTO);
        abierto_d = (estado_d == ABIERTO);
        bloqueo_d = (estado_d == BLOQUEO);
        alarma_d  = (estado_d == BLOQUEO) || ((estado_d == ESPERA_PIN) && alarma_flag_d);
    end

    assign Cerrado = cerrado_q;
    assign Abierto = abierto_q;
    assign Alarma  = alarma_q;
    assign Bloqueo = bloqueo_q;

endmodule

// File: tb/tb_controlador_estacionamiento.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural gate model.
module tb_controlador_estacionamiento;

    localparam logic [7:0]  CODE      = 8'h24;
    localparam int          MAX_TRIES = 3;

    logic       Clk;
    logic       Reset;
    logic [7:0] Pin;
    logic       Vehiculo;
    logic       Termino;
    logic       Cerrado;
    logic       Abierto;
    logic       Alarma;
    logic       Bloqueo;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 keypad, 2 gate open, 3 locked
    int m_mode;
    int m_wrong;
    bit m_alarm;

    controlador_estacionamiento dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Pin      (Pin),
        .Vehiculo (Vehiculo),
        .Termino  (Termino),
        .Cerrado  (Cerrado),
        .Abierto  (Abierto),
        .Alarma   (Alarma),
        .Bloqueo  (Bloqueo)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit rst_n, input bit veh, input bit ter,
                                       input logic [7:0] pin);
        if (!rst_n) begin
            m_mode  = 0;
            m_wrong = 0;
            m_alarm = 0;
            return;
        end
        case (m_mode)
            0: if (veh) m_mode = 1;
            1: begin
                if (pin == CODE) begin
                    m_mode  = 2;
                    m_wrong = 0;
                    m_alarm = 0;
                end else if (pin != 8'h00) begin
                    m_wrong = (m_wrong + 1 > 3) ? 3 : m_wrong + 1;
                    if (m_wrong >= MAX_TRIES) m_alarm = 1;
                end
            end
            2: if (ter) m_mode = veh ? 3 : 0;
            default: if (pin == CODE) begin
                m_mode  = 0;
                m_wrong = 0;
                m_alarm = 0;
            end
        endcase
    endfunction

    // Apply inputs for one cycle, advance the model, compare all outputs after the edge
    task automatic step(input string tag, input bit rst_n, input bit veh, input bit ter,
                        input logic [7:0] pin);
        Reset    = rst_n;
        Vehiculo = veh;
        Termino  = ter;
        Pin      = pin;
        @(posedge Clk);
        #1;
        model_step(rst_n, veh, ter, pin);
        check_eq({tag, ".cerrado"}, Cerrado, m_mode != 2);
        check_eq({tag, ".abierto"}, Abierto, m_mode == 2);
        check_eq({tag, ".bloqueo"}, Bloqueo, m_mode == 3);
        check_eq({tag, ".alarma"},  Alarma,  (m_mode == 3) || (m_mode == 1 && m_alarm));
        check_eq({tag, ".excl"},    Cerrado ^ Abierto, 1'b1);
    endtask

    initial begin
        logic [7:0] rp;
        int         sel;
        Reset = 1'b0; Vehiculo = 1'b0; Termino = 1'b0; Pin = 8'h00;
        m_mode = 0; m_wrong = 0; m_alarm = 0;

        // Reset and simple entry
        step("rst0", 0, 0, 0, 8'h00);
        step("rst1", 0, 0, 0, 8'h00);
        step("veh",  1, 1, 0, 8'h00);
        step("pin",  1, 0, 0, 8'h24);
        step("hold", 1, 0, 0, 8'h00);
        step("term", 1, 0, 1, 8'h00);

        // Wrong then right PIN
        step("w_veh",  1, 1, 0, 8'h00);
        step("w_bad",  1, 1, 0, 8'h11);
        step("w_good", 1, 1, 0, 8'h24);
        step("w_term", 1, 0, 1, 8'h00);

        // Three wrong PINs raise the alarm, correct PIN clears it
        step("a_veh", 1, 1, 0, 8'h00);
        step("a_1",   1, 0, 0, 8'h11);
        step("a_2",   1, 0, 0, 8'h22);
        step("a_3",   1, 0, 0, 8'h33);
        step("a_4",   1, 0, 0, 8'h44);
        step("a_ok",  1, 0, 0, 8'h24);

        // Tailgating lock, wrong PIN ignored, correct PIN unlocks
        step("t_tail", 1, 1, 1, 8'h00);
        step("t_bad",  1, 0, 0, 8'h33);
        step("t_hold", 1, 1, 1, 8'h00);
        step("t_ok",   1, 0, 0, 8'h24);

        // Reset mid-open and mid-lock
        step("r_veh",  1, 1, 0, 8'h00);
        step("r_pin",  1, 0, 0, 8'h24);
        step("r_open", 0, 1, 1, 8'h24);
        step("r_veh2", 1, 1, 0, 8'h00);
        step("r_pin2", 1, 0, 0, 8'h24);
        step("r_tail", 1, 1, 1, 8'h00);
        step("r_lock", 0, 0, 0, 8'h24);

        // Idle PIN is not an attempt: two wrong codes afterwards must stay silent
        step("i_veh", 1, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) step("i_idle", 1, 0, 0, 8'h00);
        step("i_w1", 1, 0, 0, 8'h55);
        step("i_w2", 1, 0, 0, 8'h66);
        step("i_w3", 1, 0, 0, 8'h77);
        step("i_ok", 1, 0, 0, 8'h24);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)       rp = 8'h00;
            else if (sel < 7)  rp = CODE;
            else               rp = 8'($urandom);
            step("rnd", ($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), rp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
